superfx_reg_writeback: RTL and testbench
========================================

# superfx_reg_writeback

Write-side controller for the SuperFX general register file R0–R15: the counterpart of the Y/X read-mux path. It commits Z-bus results into the addressed register with per-byte lane control, advances the program counter R15, executes the LOOP decrement/branch on R12/R13, and raises a ROM-fetch request whenever R14 is written. Registers are held here and exported flat to the read muxes.

## Interface
Parameters:
- RESET_VAL, 16'h0000, reset value of every register R0–R15

Ports:
- clk  in  1  register clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-low reset
- z  in  16  Z-bus write data
- zsel  in  4  destination register index
- enable_l / disable_l  in  1 / 1  low-byte write request / veto; low lane writes when enable_l & ~disable_l
- enable_h / disable_h  in  1 / 1  high-byte write request / veto; same rule for bits 15:8
- pcen  in  1  increment R15 this cycle
- cchld  in  1  cache-load hold; freezes R15 (blocks pcen and loop branch)
- loopen  in  1  execute LOOP this cycle
- rom_ack  in  1  ROM buffer accepted the fetch at rom_addr
- regs  out  256  {R15,…,R0}, registered
- rom_req  out  1  ROM fetch pending
- rom_addr  out  16  equals R14
- loop_zero  out  1  last LOOP produced R12 == 0
- rn15  out  1  one-cycle pulse: R15 loaded from Z or by loop branch

## Operation
- Z write: any enabled lane writes z into the same lane of R[zsel]; disabled lane keeps old value.
- R15 priority, high to low: Z write to R15 (any lane) > cchld hold > loop branch > pcen increment (+1, FFFF wraps to 0000).
- LOOP (loopen=1): R12 <= R12 − 1 (0000 wraps to FFFF). If result ≠ 0 and R15 not claimed by Z write or cchld, R15 <= R13 and rn15 pulses; else fall-through to pcen rule. loop_zero <= (result == 0); loop_zero otherwise holds.
- Z write to R12 together with loopen: Z write wins for R12; branch decision still uses old R12 − 1.
- Z write to R13 together with branching loopen: branch uses old R13.
- ROM request: any write to R14 sets rom_req. rom_req clears on an edge where rom_ack=1 and no R14 write occurs; an R14 write on the same edge as rom_ack keeps rom_req set (new fetch). rom_addr always tracks R14.
- Writes with both lanes disabled are no-ops (no rn15, no rom_req).

## Timing
- Reset (asynchronous, reset=0): R0–R15 = RESET_VAL, rom_req=0, loop_zero=0, rn15=0; effective immediately, any pending request dropped.
- Inputs sampled on falling edge; regs, rom_req, loop_zero, rn15 change only on that edge (1-edge latency).
- rom_req asserts on the edge committing R14; rom_ack may arrive any later edge; minimum request duration one cycle.
- rn15 high exactly one cycle after the qualifying edge.

## Configuration
- SFX_LOOP_EN defined: LOOP logic as above.
- Undefined: loopen ignored, loop_zero tied 0, R12/R13 are ordinary registers; rn15 only from Z writes to R15.

## Structure
- Package sfx_regfile_pkg: register index constants (R_LOOPCNT=12, R_LOOPADDR=13, R_ROMADDR=14, R_PC=15), 16-bit word typedef, default reset value.
- One sub-module: sfx_reg16_bytewrite — one 16-bit register with independent low/high lane enables and async active-low reset; instantiated 16 times, R12/R15 next-value muxes in the parent.

## Test plan
- Reset mid-operation with rom_req=1 and R5=1234 -> all regs 0000, rom_req=0 immediately.
- z=ABCD, zsel=3, enable_h only -> R3 = AB00 from 0000; enable_l with disable_l=1 -> R3 unchanged.
- R15=FFFF, pcen=1 -> R15=0000; same with cchld=1 -> R15 stays FFFF; Z write 8000 to R15 with pcen=1 -> R15=8000, rn15 pulse.
- R12=0002, R13=0100, loopen -> R12=0001, R15=0100, loop_zero=0; repeat -> R12=0000, R15 increments per pcen, loop_zero=1; R12=0000 loopen -> R12=FFFF, branch taken.
- Write R14=4000 -> rom_req=1, rom_addr=4000; rom_ack with simultaneous R14=4002 write -> rom_req stays 1, rom_addr=4002; next rom_ack alone -> rom_req=0.
- SFX_LOOP_EN undefined: loopen=1 with R12=0005 -> R12 unchanged, loop_zero=0.

Source files
------------

// File: rtl/sfx_regfile_pkg.sv
// Shared definitions for the SuperFX general register file write side:
// register index constants, the 16-bit word type and the default reset value.
package sfx_regfile_pkg;

    typedef logic [15:0] word_t;

    localparam logic [3:0] R_LOOPCNT  = 4'd12;
    localparam logic [3:0] R_LOOPADDR = 4'd13;
    localparam logic [3:0] R_ROMADDR  = 4'd14;
    localparam logic [3:0] R_PC       = 4'd15;

    localparam word_t SFX_RESET_VAL = 16'h0000;

    // Decrement with natural wrap (0000 -> FFFF), used by the LOOP counter.
    function automatic word_t word_dec(input word_t v);
        return v - 16'h0001;
    endfunction

    // Increment with natural wrap (FFFF -> 0000), used by the program counter.
    function automatic word_t word_inc(input word_t v);
        return v + 16'h0001;
    endfunction

endpackage

// File: rtl/sfx_reg16_bytewrite.sv
// One 16-bit general register with independent low/high byte-lane write
// enables. Updates on the falling clock edge; asynchronous active-low reset.
module sfx_reg16_bytewrite
    import sfx_regfile_pkg::*;
#(
    parameter word_t RESET_VAL = SFX_RESET_VAL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_l,
    input  logic        we_h,
    input  logic [15:0] d,
    output logic [15:0] q
);

    // Byte-lane storage: each enabled lane takes the matching byte of d.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else begin
            if (we_l) begin
                q[7:0] <= d[7:0];
            end
            if (we_h) begin
                q[15:8] <= d[15:8];
            end
        end
    end

endmodule

// File: rtl/superfx_reg_writeback.sv
// SuperFX register-file write-back controller: commits Z-bus results into
// R0-R15 with per-lane control, advances R15, runs LOOP on R12/R13 and raises
// a ROM fetch request on every R14 write.
// Optional feature macro: SFX_LOOP_EN (LOOP decrement/branch). When it is not
// defined, loopen is ignored, loop_zero stays 0 and R12/R13 are plain registers.
module superfx_reg_writeback
    import sfx_regfile_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = SFX_RESET_VAL
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  z,
    input  logic [3:0]   zsel,
    input  logic         enable_l,
    input  logic         disable_l,
    input  logic         enable_h,
    input  logic         disable_h,
    input  logic         pcen,
    input  logic         cchld,
    input  logic         loopen,
    input  logic         rom_ack,
    output logic [255:0] regs,
    output logic         rom_req,
    output logic [15:0]  rom_addr,
    output logic         loop_zero,
    output logic         rn15
);

    logic        wr_l_s;
    logic        wr_h_s;
    logic        zwr_s;
    logic        zwr_r12_s;
    logic        zwr_r14_s;
    logic        zwr_r15_s;
    logic        loop_act_s;
    logic        loop_nz_s;
    logic        branch_s;
    word_t       dec_s;
    logic [15:0] we_l_s;
    logic [15:0] we_h_s;
    word_t       d_s [16];
    word_t       q_s [16];
    logic        rom_req_r;
    logic        loop_zero_r;
    logic        rn15_r;

    assign wr_l_s    = enable_l & ~disable_l;
    assign wr_h_s    = enable_h & ~disable_h;
    assign zwr_s     = wr_l_s | wr_h_s;
    assign zwr_r12_s = zwr_s & (zsel == R_LOOPCNT);
    assign zwr_r14_s = zwr_s & (zsel == R_ROMADDR);
    assign zwr_r15_s = zwr_s & (zsel == R_PC);

`ifdef SFX_LOOP_EN
    assign loop_act_s = loopen;
`else
    assign loop_act_s = loopen & 1'b0;
`endif

    // The branch decision always uses the pre-edge R12/R13 values.
    assign dec_s     = word_dec(q_s[R_LOOPCNT]);
    assign loop_nz_s = (dec_s != 16'h0000);
    assign branch_s  = loop_act_s & loop_nz_s & ~zwr_r15_s & ~cchld;

    // Per-register lane enables and next data, with R12/R15 special muxes.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            we_l_s[i] = wr_l_s & (zsel == 4'(i));
            we_h_s[i] = wr_h_s & (zsel == 4'(i));
            d_s[i]    = z;
        end

        // R12: a Z write owns the register; otherwise LOOP decrements it.
        if (!zwr_r12_s && loop_act_s) begin
            we_l_s[R_LOOPCNT] = 1'b1;
            we_h_s[R_LOOPCNT] = 1'b1;
            d_s[R_LOOPCNT]    = dec_s;
        end else begin
            d_s[R_LOOPCNT]    = z;
        end

        // R15 priority: Z write > cache-load hold > loop branch > pcen.
        if (zwr_r15_s) begin
            d_s[R_PC] = z;
        end else if (cchld) begin
            we_l_s[R_PC] = 1'b0;
            we_h_s[R_PC] = 1'b0;
        end else if (branch_s) begin
            we_l_s[R_PC] = 1'b1;
            we_h_s[R_PC] = 1'b1;
            d_s[R_PC]    = q_s[R_LOOPADDR];
        end else if (pcen) begin
            we_l_s[R_PC] = 1'b1;
            we_h_s[R_PC] = 1'b1;
            d_s[R_PC]    = word_inc(q_s[R_PC]);
        end else begin
            d_s[R_PC]    = z;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_reg
        sfx_reg16_bytewrite #(
            .RESET_VAL (RESET_VAL)
        ) u_reg (
            .clk  (clk),
            .reset(reset),
            .we_l (we_l_s[g]),
            .we_h (we_h_s[g]),
            .d    (d_s[g]),
            .q    (q_s[g])
        );
        assign regs[16*g +: 16] = q_s[g];
    end

    // Status flags: ROM request handshake, loop-zero result and R15 load pulse.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            rom_req_r   <= 1'b0;
            loop_zero_r <= 1'b0;
            rn15_r      <= 1'b0;
        end else begin
            if (zwr_r14_s) begin
                rom_req_r <= 1'b1;
            end else if (rom_ack) begin
                rom_req_r <= 1'b0;
            end
            if (loop_act_s) begin
                loop_zero_r <= ~loop_nz_s;
            end
            rn15_r <= zwr_r15_s | branch_s;
        end
    end

    assign rom_req   = rom_req_r;
    assign rom_addr  = q_s[R_ROMADDR];
    assign loop_zero = loop_zero_r;
    assign rn15      = rn15_r;

endmodule

// File: tb/tb_superfx_reg_writeback.sv
// Self-checking bench for superfx_reg_writeback: directed scenarios plus a
// randomized run, all checked against a behavioural model of the register file.
// Honours SFX_LOOP_EN the same way the design does.
module tb_superfx_reg_writeback;

`ifdef SFX_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic         clk = 1'b1;
    logic         reset = 1'b0;
    logic [15:0]  z = 16'h0000;
    logic [3:0]   zsel = 4'd0;
    logic         enable_l = 1'b0;
    logic         disable_l = 1'b0;
    logic         enable_h = 1'b0;
    logic         disable_h = 1'b0;
    logic         pcen = 1'b0;
    logic         cchld = 1'b0;
    logic         loopen = 1'b0;
    logic         rom_ack = 1'b0;
    logic [255:0] regs;
    logic         rom_req;
    logic [15:0]  rom_addr;
    logic         loop_zero;
    logic         rn15;

    int total = 0;
    int bad = 0;

    // Behavioural model state
    logic [15:0] m_reg [16];
    logic        m_req;
    logic        m_lz;
    logic        m_rn15;

    superfx_reg_writeback dut (
        .clk      (clk),
        .reset    (reset),
        .z        (z),
        .zsel     (zsel),
        .enable_l (enable_l),
        .disable_l(disable_l),
        .enable_h (enable_h),
        .disable_h(disable_h),
        .pcen     (pcen),
        .cchld    (cchld),
        .loopen   (loopen),
        .rom_ack  (rom_ack),
        .regs     (regs),
        .rom_req  (rom_req),
        .rom_addr (rom_addr),
        .loop_zero(loop_zero),
        .rn15     (rn15)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] exp_regs();
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[16*i +: 16] = m_reg[i];
        return v;
    endfunction

    function automatic logic [15:0] dut_reg(input int idx);
        return regs[16*idx +: 16];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
        m_req  = 1'b0;
        m_lz   = 1'b0;
        m_rn15 = 1'b0;
    endtask

    // Apply one falling edge worth of the operation rules to the model.
    task automatic model_step();
        logic [15:0] old [16];
        logic lo, hi, zw;
        int   cnt;
        for (int i = 0; i < 16; i++) old[i] = m_reg[i];
        lo  = enable_l && !disable_l;
        hi  = enable_h && !disable_h;
        zw  = lo || hi;
        cnt = (int'(old[12]) + 65535) % 65536;
        if (lo) m_reg[zsel][7:0]  = z[7:0];
        if (hi) m_reg[zsel][15:8] = z[15:8];
        m_rn15 = 1'b0;
        if (LOOP && loopen) begin
            if (!(zw && zsel == 4'd12)) m_reg[12] = 16'(cnt);
            m_lz = (cnt == 0);
        end
        if (zw && zsel == 4'd15) begin
            m_rn15 = 1'b1;
        end else if (cchld) begin
            m_reg[15] = old[15];
        end else if (LOOP && loopen && cnt != 0) begin
            m_reg[15] = old[13];
            m_rn15    = 1'b1;
        end else if (pcen) begin
            m_reg[15] = 16'((int'(old[15]) + 1) % 65536);
        end
        if (zw && zsel == 4'd14) m_req = 1'b1;
        else if (rom_ack) m_req = 1'b0;
    endtask

    task automatic idle_inputs();
        enable_l = 1'b0; disable_l = 1'b0; enable_h = 1'b0; disable_h = 1'b0;
        pcen = 1'b0; cchld = 1'b0; loopen = 1'b0; rom_ack = 1'b0;
    endtask

    // Advance one falling edge and update the model; outputs sampled 1 time unit later.
    task automatic tick();
        @(negedge clk);
        model_step();
        #1;
    endtask

    task automatic write_reg(input logic [3:0] idx, input logic [15:0] val);
        idle_inputs();
        z = val; zsel = idx; enable_l = 1'b1; enable_h = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #3;
        total++;
        if (regs !== 256'h0 || rom_req !== 1'b0 || loop_zero !== 1'b0 || rn15 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state regs=%h req=%b lz=%b rn15=%b required all zero", regs, rom_req, loop_zero, rn15);
        end
        @(posedge clk);
        reset = 1'b1;
    endtask

    task automatic test_lanes();
        idle_inputs();
        z = 16'hABCD; zsel = 4'd3; enable_h = 1'b1;
        tick();
        total++;
        if (dut_reg(3) !== 16'hAB00) begin
            bad++; $display("FAIL lane_high R3=%h required AB00", dut_reg(3));
        end
        idle_inputs();
        z = 16'h1234; zsel = 4'd3; enable_l = 1'b1; disable_l = 1'b1;
        tick();
        total++;
        if (dut_reg(3) !== 16'hAB00) begin
            bad++; $display("FAIL lane_veto R3=%h required AB00", dut_reg(3));
        end
        idle_inputs();
        z = 16'h5566; zsel = 4'd3; enable_l = 1'b1;
        tick();
        total++;
        if (dut_reg(3) !== 16'hAB66 || regs !== exp_regs()) begin
            bad++; $display("FAIL lane_low R3=%h required AB66", dut_reg(3));
        end
        idle_inputs();
        z = 16'hFFFF; zsel = 4'd15; enable_l = 1'b1; disable_l = 1'b1; enable_h = 1'b1; disable_h = 1'b1;
        tick();
        total++;
        if (rn15 !== 1'b0 || regs !== exp_regs()) begin
            bad++; $display("FAIL both_vetoed rn15=%b required 0 regs=%h", rn15, regs);
        end
        idle_inputs();
    endtask

    task automatic test_pc();
        write_reg(4'd15, 16'hFFFF);
        total++;
        if (dut_reg(15) !== 16'hFFFF || rn15 !== 1'b1) begin
            bad++; $display("FAIL pc_zload R15=%h rn15=%b required FFFF 1", dut_reg(15), rn15);
        end
        pcen = 1'b1;
        tick();
        total++;
        if (dut_reg(15) !== 16'h0000 || rn15 !== 1'b0) begin
            bad++; $display("FAIL pc_wrap R15=%h rn15=%b required 0000 0", dut_reg(15), rn15);
        end
        write_reg(4'd15, 16'hFFFF);
        pcen = 1'b1; cchld = 1'b1;
        tick();
        total++;
        if (dut_reg(15) !== 16'hFFFF) begin
            bad++; $display("FAIL pc_hold R15=%h required FFFF", dut_reg(15));
        end
        idle_inputs();
        z = 16'h8000; zsel = 4'd15; enable_l = 1'b1; enable_h = 1'b1; pcen = 1'b1;
        tick();
        total++;
        if (dut_reg(15) !== 16'h8000 || rn15 !== 1'b1) begin
            bad++; $display("FAIL pc_zwin R15=%h rn15=%b required 8000 1", dut_reg(15), rn15);
        end
        idle_inputs();
        tick();
        total++;
        if (rn15 !== 1'b0) begin
            bad++; $display("FAIL rn15_pulse rn15=%b required 0", rn15);
        end
    endtask

    task automatic test_loop();
        write_reg(4'd12, 16'h0002);
        write_reg(4'd13, 16'h0100);
        write_reg(4'd15, 16'h0050);
        tick();
        loopen = 1'b1;
        tick();
        total++;
        if (LOOP && (dut_reg(12) !== 16'h0001 || dut_reg(15) !== 16'h0100 || loop_zero !== 1'b0 || rn15 !== 1'b1)) begin
            bad++; $display("FAIL loop_branch R12=%h R15=%h lz=%b rn15=%b required 0001 0100 0 1", dut_reg(12), dut_reg(15), loop_zero, rn15);
        end else if (!LOOP && (dut_reg(12) !== 16'h0002 || dut_reg(15) !== 16'h0050 || loop_zero !== 1'b0 || rn15 !== 1'b0)) begin
            bad++; $display("FAIL loop_ignored R12=%h R15=%h lz=%b rn15=%b required 0002 0050 0 0", dut_reg(12), dut_reg(15), loop_zero, rn15);
        end
        loopen = 1'b1; pcen = 1'b1;
        tick();
        total++;
        if (LOOP && (dut_reg(12) !== 16'h0000 || dut_reg(15) !== 16'h0101 || loop_zero !== 1'b1 || rn15 !== 1'b0)) begin
            bad++; $display("FAIL loop_fall R12=%h R15=%h lz=%b required 0000 0101 1", dut_reg(12), dut_reg(15), loop_zero);
        end
        loopen = 1'b1; pcen = 1'b0;
        tick();
        total++;
        if (LOOP && (dut_reg(12) !== 16'hFFFF || dut_reg(15) !== 16'h0100 || loop_zero !== 1'b0)) begin
            bad++; $display("FAIL loop_wrap R12=%h R15=%h lz=%b required FFFF 0100 0", dut_reg(12), dut_reg(15), loop_zero);
        end
        idle_inputs();
        write_reg(4'd12, 16'h0005);
        loopen = 1'b1;
        z = 16'h0777; zsel = 4'd13; enable_l = 1'b1; enable_h = 1'b1;
        tick();
        total++;
        if (regs !== exp_regs() || loop_zero !== m_lz || rn15 !== m_rn15) begin
            bad++; $display("FAIL loop_r13_old R12=%h R13=%h R15=%h required %h %h %h", dut_reg(12), dut_reg(13), dut_reg(15), m_reg[12], m_reg[13], m_reg[15]);
        end
        idle_inputs();
    endtask

    task automatic test_rom();
        write_reg(4'd14, 16'h4000);
        total++;
        if (rom_req !== 1'b1 || rom_addr !== 16'h4000) begin
            bad++; $display("FAIL rom_set req=%b addr=%h required 1 4000", rom_req, rom_addr);
        end
        z = 16'h4002; zsel = 4'd14; enable_l = 1'b1; enable_h = 1'b1; rom_ack = 1'b1;
        tick();
        total++;
        if (rom_req !== 1'b1 || rom_addr !== 16'h4002) begin
            bad++; $display("FAIL rom_refetch req=%b addr=%h required 1 4002", rom_req, rom_addr);
        end
        idle_inputs();
        rom_ack = 1'b1;
        tick();
        total++;
        if (rom_req !== 1'b0 || rom_addr !== 16'h4002) begin
            bad++; $display("FAIL rom_ack req=%b addr=%h required 0 4002", rom_req, rom_addr);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            z = 16'($urandom);
            zsel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) zsel = 4'($urandom_range(12, 15));
            enable_l  = 1'($urandom); disable_l = ($urandom_range(0, 3) == 0);
            enable_h  = 1'($urandom); disable_h = ($urandom_range(0, 3) == 0);
            pcen   = 1'($urandom);
            cchld  = ($urandom_range(0, 4) == 0);
            loopen = ($urandom_range(0, 2) == 0);
            rom_ack = 1'($urandom);
            tick();
            total++;
            if (regs !== exp_regs() || rom_req !== m_req || loop_zero !== m_lz || rn15 !== m_rn15 || rom_addr !== m_reg[14]) begin
                bad++;
                if (errs < 5) $display("FAIL random cyc=%0d req=%b/%b lz=%b/%b rn15=%b/%b R12=%h/%h R15=%h/%h (actual/required)",
                    c, rom_req, m_req, loop_zero, m_lz, rn15, m_rn15, dut_reg(12), m_reg[12], dut_reg(15), m_reg[15]);
                errs++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        write_reg(4'd5, 16'h1234);
        write_reg(4'd14, 16'h2222);
        total++;
        if (rom_req !== 1'b1 || dut_reg(5) !== 16'h1234) begin
            bad++; $display("FAIL pre_reset req=%b R5=%h required 1 1234", rom_req, dut_reg(5));
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (regs !== 256'h0 || rom_req !== 1'b0 || rn15 !== 1'b0 || loop_zero !== 1'b0) begin
            bad++; $display("FAIL reset_mid regs=%h req=%b required zero 0", regs, rom_req);
        end
        @(posedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lanes();
        test_pc();
        test_loop();
        test_rom();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
